// File: rtl/cve2_load_resp.sv
// cve2_load_resp: tracks one LSU access, merges split words and extends load data for writeback
module cve2_load_resp (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_SECOND} state_e;
  state_e      state_q, state_d;
  logic        we_q, sign_q, split_q, err_q;
  logic [1:0]  type_q, off_q;
  logic [31:8] rdata_q;
  logic        split_req, accept, first_split, final_resp;
  logic        is_word, is_half;
  logic [31:0] word_v, ext_v;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  assign split_req   = (req_type_i[0] == req_type_i[1]) ? (req_offset_i != 2'd0)
                     : (req_type_i == 2'b01) & (req_offset_i == 2'd3);
  assign final_resp  = data_rvalid_i & ((state_q == WAIT_FIRST & ~split_q) | state_q == WAIT_SECOND);
  assign first_split = data_rvalid_i & (state_q == WAIT_FIRST) & split_q;
  assign req_ready_o = (state_q == IDLE) | final_resp;
  assign accept      = req_valid_i & req_ready_o;
  assign busy_o      = state_q != IDLE;
  always_comb begin
    state_d = accept ? WAIT_FIRST : first_split ? WAIT_SECOND : final_resp ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      split_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        type_q  <= req_type_i;
        sign_q  <= req_sign_ext_i;
        off_q   <= req_offset_i;
        split_q <= split_req;
      end
      if (first_split) rdata_q <= data_rdata_i[31:8];
      err_q <= first_split ? data_err_i : (final_resp | accept) ? 1'b0 : err_q;
    end
  end
  // rdata_q holds the first bus word; the second word is taken live from the bus
  assign is_word = type_q[0] == type_q[1];
  assign is_half = type_q == 2'b01;
  assign word_v  = !split_q ? data_rdata_i
                 : off_q == 2'd1 ? {data_rdata_i[7:0], rdata_q[31:8]}
                 : off_q == 2'd2 ? {data_rdata_i[15:0], rdata_q[31:16]}
                 : {data_rdata_i[23:0], rdata_q[31:24]};
  assign half_v  = split_q ? {data_rdata_i[7:0], rdata_q[31:24]}
                 : off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
  assign byte_v  = data_rdata_i[{off_q, 3'b000} +: 8];
  assign ext_v   = is_word ? word_v
                 : is_half ? {{16{sign_q & half_v[15]}}, half_v}
                 : {{24{sign_q & byte_v[7]}}, byte_v};
  assign lsu_resp_valid_o = final_resp;
  assign lsu_resp_err_o   = final_resp & (data_err_i | err_q);
  assign rf_we_lsu_o      = final_resp & ~we_q & ~lsu_resp_err_o;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? ext_v : 32'd0;
  a_req_ready: assert property (@(posedge clk_i) disable iff (!rst_ni) req_valid_i |-> req_ready_o);
  a_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> state_q != IDLE);
endmodule

// File: doc/cve2_load_resp.md
Name: cve2_load_resp

Overview:
- Load/store response stage between the data-bus interface and the writeback passthrough.
- Tracks one outstanding memory access at a time, including misaligned accesses that split into two bus words.
- Extracts, merges and sign/zero-extends load data, then drives rf_we_lsu / rf_wdata_lsu plus the lsu_resp_valid / lsu_resp_err pair consumed by writeback and perf counting.

Parameters:
- None. Fixed 32-bit data path.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset: asynchronous assert, active low
req_valid_i  input  1  access issued and granted on bus this cycle
req_ready_o  output  1  new access may be issued this cycle
req_we_i  input  1  1 = store (no RF write), 0 = load
req_type_i  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
req_sign_ext_i  input  1  sign-extend half/byte loads
req_offset_i  input  2  address bits [1:0]
data_rvalid_i  input  1  bus response valid
data_rdata_i  input  32  bus response data
data_err_i  input  1  bus response error, qualified by rvalid
rf_we_lsu_o  output  1  RF write enable for load data
rf_wdata_lsu_o  output  32  aligned and extended load data
lsu_resp_valid_o  output  1  final response of access this cycle
lsu_resp_err_o  output  1  access faulted, qualified by resp_valid
busy_o  output  1  access outstanding

Behaviour:
- States: IDLE, WAIT_FIRST, WAIT_SECOND. Reset: IDLE; all captured registers 0; outputs req_ready_o=1, others 0.
- Split condition at issue: word with offset!=0, or half with offset==3.
- On accept (req_valid_i & req_ready_o), latch we/type/sign_ext/offset/split; go to WAIT_FIRST.
- WAIT_FIRST + rvalid, split: capture rdata into rdata_q and error into err_q; go to WAIT_SECOND. No outputs asserted.
- WAIT_FIRST + rvalid, not split: final response. WAIT_SECOND + rvalid: final response.
- Final response cycle, combinational from rvalid, zero latency:
  - lsu_resp_valid_o=1; lsu_resp_err_o = data_err_i | err_q.
  - rf_we_lsu_o = ~we_q & ~lsu_resp_err_o.
  - Next state: IDLE, or WAIT_FIRST if a new request is accepted the same cycle.
- req_ready_o = (state==IDLE) | final-response cycle. Back-to-back issue is allowed with no bubble.
- req_valid_i while req_ready_o=0: ignored. An assertion flags it.
- data_rvalid_i in IDLE: ignored, no outputs. An assertion flags it.
- Aligned extraction (non-split), data = data_rdata_i:
  - word: data.
  - half: data[16*offset[1] +: 16].
  - byte: data[8*offset +: 8].
- Split merge, r1 = rdata_q, r2 = data_rdata_i:
  - word off1 = {r2[7:0], r1[31:8]}; off2 = {r2[15:0], r1[31:16]}; off3 = {r2[23:0], r1[31:24]}.
  - half off3 = {r2[7:0], r1[31:24]}.
- Extension: half/byte are sign-extended from the top extracted bit when sign_ext_q=1, else zero-extended.
- rf_wdata_lsu_o is 0 whenever rf_we_lsu_o=0, so the writeback OR-mux stays clean.
- Error on the first part of a split: err_q stays set; the second part is still awaited; single response with err=1 and no RF write.
- busy_o = (state != IDLE).
- Reset mid-operation: immediate return to IDLE; captured data and error cleared; any later stray rvalid is ignored.

Test Plan:
- LW off0, rdata 0xDEADBEEF -> one cycle later resp_valid=1, we=1, wdata 0xDEADBEEF.
- LH signed off2, rdata 0x8001_1234 -> wdata 0xFFFF8001. Same access unsigned -> 0x00008001. LB signed off3, rdata 0x7F00_0000 -> 0x0000007F.
- LW off1 split, first 0x44332211, second 0x88776655 -> no response after first; final wdata 0x55443322, we=1.
- LH off3 split, first 0xAB000000, second 0x000000CD, signed -> 0xFFFFCDAB.
- Split LW with data_err_i on first part only -> single response, err=1, we=0, wdata 0, state IDLE.
- Store, then a load issued in the store's response cycle -> store gives resp_valid=1, we=0; load accepted without bubble. Separately, reset asserted in WAIT_SECOND -> IDLE, busy_o=0, later rvalid produces no output.
